// File: rtl/apu_issue_buffer_pkg.sv
// Shared types for the APU issue buffer.
//   apu_req_t         : one core APU request (operands a/b/c, opcode, flags)
//   apu_issue_state_t : issue FSM states
package apu_issue_buffer_pkg;

    localparam int unsigned APU_NUM_OPERANDS = 3;
    localparam int unsigned APU_WIDTH        = 32;
    localparam int unsigned APU_OP_W         = 6;
    localparam int unsigned APU_FLAGS_W      = 15;

    typedef struct packed {
        logic [APU_NUM_OPERANDS-1:0][APU_WIDTH-1:0] operands;
        logic [APU_OP_W-1:0]                        op;
        logic [APU_FLAGS_W-1:0]                     flags;
    } apu_req_t;

    typedef enum logic [1:0] {
        ISSUE_IDLE = 2'd0,
        ISSUE_REQ  = 2'd1,
        ISSUE_WAIT = 2'd2
    } apu_issue_state_t;

endpackage

// File: rtl/apu_issue_buffer_if.sv
// APU request/result channel, used on both sides of the issue buffer.
//   req    : request valid (requester -> responder)
//   data   : request payload (requester -> responder)
//   gnt    : request accepted (responder -> requester)
//   rvalid : result valid (responder -> requester)
//   result : result value (responder -> requester)
// master = requester side, slave = responder side.
interface apu_issue_buffer_if;
    import apu_issue_buffer_pkg::*;

    logic                 req;
    apu_req_t             data;
    logic                 gnt;
    logic                 rvalid;
    logic [APU_WIDTH-1:0] result;

    modport master (output req, output data, input gnt, input rvalid, input result);
    modport slave  (input req, input data, output gnt, output rvalid, output result);

endinterface

// File: rtl/apu_issue_buffer_req_fifo.sv
// Synchronous FIFO of apu_req_t entries.
//   clk, reset : clock, asynchronous active-high reset
//   push/push_data : write an entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   head           : current head entry (undefined when empty)
//   full/empty/count : occupancy status
module apu_issue_buffer_req_fifo
    import apu_issue_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  apu_req_t         push_data,
    input  logic             pop,
    output apu_req_t         head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    apu_req_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed through count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/apu_issue_buffer.sv
// In-order issue buffer between the core APU port and the accelerator.
// Core requests are queued in a DEPTH-entry FIFO and issued one at a time;
// each accelerator result is returned to the core as a registered
// single-cycle rvalid pulse.
//   clk, reset   : clock, asynchronous active-high reset
//   core (slave) : core request in, gnt/rvalid/result out
//   acc (master) : head request out, gnt/rvalid/result in
//   occupancy_o  : number of queued entries
module apu_issue_buffer
    import apu_issue_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    apu_issue_buffer_if.slave         core,
    apu_issue_buffer_if.master        acc,
    output logic [CNT_W-1:0]          occupancy_o
);

    apu_issue_state_t     state;
    apu_req_t             head;
    logic                 full;
    logic                 empty;
    logic [CNT_W-1:0]     count;
    logic                 pop;
    logic                 capture;
    logic                 acc_req_q;
    logic                 rvalid_q;
    logic [APU_WIDTH-1:0] result_q;

    // No pass-through when full, even if the head pops this cycle.
    assign core.gnt = core.req && !full && !reset;

    assign pop     = (state == ISSUE_REQ) && acc.gnt;
    // A result is only legal in WAIT or together with the grant in REQ.
    assign capture = acc.rvalid && ((state == ISSUE_WAIT) || pop);

    apu_issue_buffer_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (core.gnt),
        .push_data (core.data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ISSUE_IDLE;
            acc_req_q <= 1'b0;
            rvalid_q  <= 1'b0;
            result_q  <= '0;
        end else begin
            rvalid_q <= capture;
            if (capture) result_q <= acc.result;
            case (state)
                ISSUE_IDLE: begin
                    if (!empty) begin
                        state     <= ISSUE_REQ;
                        acc_req_q <= 1'b1;
                    end
                end
                ISSUE_REQ: begin
                    if (acc.gnt) begin
                        acc_req_q <= 1'b0;
                        state     <= acc.rvalid ? ISSUE_IDLE : ISSUE_WAIT;
                    end
                end
                ISSUE_WAIT: begin
                    if (acc.rvalid) begin
                        if (!empty) begin
                            state     <= ISSUE_REQ;
                            acc_req_q <= 1'b1;
                        end else begin
                            state <= ISSUE_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= ISSUE_IDLE;
                    acc_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Head is stable while requesting because it only moves on a pop.
    assign acc.req     = acc_req_q;
    assign acc.data    = acc_req_q ? head : '0;
    assign core.rvalid = rvalid_q;
    assign core.result = result_q;
    assign occupancy_o = count;

    // An unexpected accelerator result is dropped; flag it in simulation.
    rvalid_protocol: assert property (@(posedge clk) disable iff (reset)
        acc.rvalid |-> ((state == ISSUE_WAIT) || ((state == ISSUE_REQ) && acc.gnt)));

endmodule
